// File: rtl/stride_counter_pkg.sv
// stride_counter_pkg: shared types and elaboration helpers for stride_counter.
// Contents:
//   dir_e     - count direction (DIR_UP = 0, DIR_DOWN = 1)
//   calc_top  - highest on-grid value START + k*STEP that does not exceed LIMIT
package stride_counter_pkg;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    // A zero stride is rejected at elaboration, so here it only needs to avoid a divide by zero.
    function automatic longint calc_top(longint start, longint step, longint limit);
        return (step == 0) ? start : start + ((limit - start) / step) * step;
    endfunction

endpackage

// File: rtl/stride_next.sv
// stride_next: combinational next-value and wrap calculator for stride_counter.
// Ports:
//   count_i  in  WIDTH  current count
//   dir_i    in  1      0 = up, 1 = down
//   next_o   out WIDTH  value after one step
//   wrap_o   out 1      step crosses a boundary (wrap, or blocked when saturating)
// Macro STRIDE_COUNTER_SAT_EN: boundary steps hold the count instead of wrapping.
module stride_next
    import stride_counter_pkg::*;
#(
    parameter int     WIDTH = 8,
    parameter longint START = 1,
    parameter longint STEP  = 2,
    parameter longint LIMIT = (longint'(1) << WIDTH) - 1
) (
    input  logic [WIDTH-1:0] count_i,
    input  logic             dir_i,
    output logic [WIDTH-1:0] next_o,
    output logic             wrap_o
);

    localparam logic [WIDTH:0]   START_X = (WIDTH+1)'(START);
    localparam logic [WIDTH:0]   STEP_X  = (WIDTH+1)'(STEP);
    localparam logic [WIDTH:0]   LIMIT_X = (WIDTH+1)'(LIMIT);
    localparam logic [WIDTH:0]   LOW_X   = START_X + STEP_X;
    localparam logic [WIDTH-1:0] STEP_W  = WIDTH'(STEP);

    logic [WIDTH:0]   up_x;
    logic [WIDTH-1:0] dn_w;
    logic             down;

    // The extra bit keeps count+STEP from overflowing and count<START+STEP from underflowing.
    always_comb begin
        up_x   = {1'b0, count_i} + STEP_X;
        dn_w   = count_i - STEP_W;
        down   = dir_e'(dir_i) == DIR_DOWN;
        wrap_o = down ? ({1'b0, count_i} < LOW_X) : (up_x > LIMIT_X);
`ifdef STRIDE_COUNTER_SAT_EN
        next_o = wrap_o ? count_i : (down ? dn_w : up_x[WIDTH-1:0]);
`else
        next_o = down ? (wrap_o ? WIDTH'(calc_top(START, STEP, LIMIT)) : dn_w)
                      : (wrap_o ? START_X[WIDTH-1:0] : up_x[WIDTH-1:0]);
`endif
    end

endmodule

// File: rtl/stride_counter.sv
// stride_counter: programmable arithmetic-sequence counter (START, START+STEP, ... up to LIMIT).
// Ports:
//   clk          in  1      rising-edge clock
//   reset_n      in  1      asynchronous active-low reset
//   en           in  1      advance one step
//   dir          in  1      0 = up, 1 = down
//   clear        in  1      synchronous return to START (highest priority)
//   load         in  1      synchronous parallel load of load_val
//   load_val     in  WIDTH  value taken on load
//   counter_out  out WIDTH  registered count
//   wrap         out 1      registered one-cycle pulse after a wrap step
// Macro STRIDE_COUNTER_SAT_EN: saturate at START/LIMIT; wrap then flags blocked steps.
module stride_counter
    import stride_counter_pkg::*;
#(
    parameter int     WIDTH = 8,
    parameter longint START = 1,
    parameter longint STEP  = 2,
    parameter longint LIMIT = (longint'(1) << WIDTH) - 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             dir,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] counter_out,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] START_W = WIDTH'(START);

    if (STEP < 1 || START > LIMIT || LIMIT > (longint'(1) << WIDTH) - 1) begin : g_bad_cfg
        $error("stride_counter: illegal STEP/START/LIMIT for WIDTH");
    end

    logic [WIDTH-1:0] cnt_q, cnt_d, step_val;
    logic             wrap_q, wrap_d, step_wrap;

    stride_next #(
        .WIDTH (WIDTH),
        .START (START),
        .STEP  (STEP),
        .LIMIT (LIMIT)
    ) u_next (
        .count_i (cnt_q),
        .dir_i   (dir),
        .next_o  (step_val),
        .wrap_o  (step_wrap)
    );

    always_comb begin
        cnt_d  = clear ? START_W : load ? load_val : en ? step_val : cnt_q;
        wrap_d = !clear && !load && en && step_wrap;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q  <= START_W;
            wrap_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            wrap_q <= wrap_d;
        end
    end

    assign counter_out = cnt_q;
    assign wrap        = wrap_q;

endmodule

// File: tb/tb_stride_counter.sv
// tb_stride_counter: self-checking bench for stride_counter (default and a small 4-bit instance).
module tb_stride_counter;
    import stride_counter_pkg::*;

`ifdef STRIDE_COUNTER_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic       clk = 1'b0, reset_n = 1'b0;
    logic       en = 1'b0, dir = 1'b0, clear = 1'b0, load = 1'b0;
    logic [7:0] lv_a = '0, cnt_a;
    logic [3:0] lv_b = '0, cnt_b;
    logic       wrap_a, wrap_b;
    int         checks = 0, errors = 0;

    typedef struct packed {logic w; longint c;} mres_t;
    typedef struct {bit clr; bit ld; logic [7:0] lv; bit en; bit dir; logic [7:0] cnt; bit wr;} vec_t;

    longint ma = 1, mb = 0;
    bit     wa = 0, wb = 0;
    vec_t   tbl[$];

    always #5 clk = ~clk;

    stride_counter dut_a (
        .clk(clk), .reset_n(reset_n), .en(en), .dir(dir), .clear(clear), .load(load),
        .load_val(lv_a), .counter_out(cnt_a), .wrap(wrap_a)
    );

    stride_counter #(.WIDTH(4), .START(0), .STEP(3), .LIMIT(13)) dut_b (
        .clk(clk), .reset_n(reset_n), .en(en), .dir(dir), .clear(clear), .load(load),
        .load_val(lv_b), .counter_out(cnt_b), .wrap(wrap_b)
    );

    // Reference: the sequence rules applied with plain integer arithmetic.
    function automatic mres_t mstep(longint c, bit clr, bit ld, longint lv, bit e, bit d,
                                    longint start, longint step, longint limit);
        longint top = calc_top(start, step, limit);
        if (clr) return '{1'b0, start};
        if (ld) return '{1'b0, lv};
        if (!e) return '{1'b0, c};
        if (!d) return (c + step > limit) ? '{1'b1, SAT ? c : start} : '{1'b0, c + step};
        return (c - step < start) ? '{1'b1, SAT ? c : top} : '{1'b0, c - step};
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drv(input bit c, input bit l, input logic [7:0] v, input bit e, input bit d);
        clear = c; load = l; lv_a = v; lv_b = v[3:0]; en = e; dir = d;
    endtask

    task automatic tick();
        mres_t ra, rb;
        @(posedge clk);
        ra = mstep(ma, clear, load, longint'(lv_a), en, dir, 1, 2, 255);
        rb = mstep(mb, clear, load, longint'(lv_b), en, dir, 0, 3, 13);
        ma = ra.c; wa = ra.w; mb = rb.c; wb = rb.w;
        @(negedge clk);
        chk("model A cnt", longint'(cnt_a), ma);
        chk("model A wrap", longint'(wrap_a), longint'(wa));
        chk("model B cnt", longint'(cnt_b), mb);
        chk("model B wrap", longint'(wrap_b), longint'(wb));
    endtask

    initial begin
`ifdef STRIDE_COUNTER_SAT_EN
        tbl.push_back('{0,0,8'd0,1,1,8'd1,1});
        tbl.push_back('{0,0,8'd0,1,1,8'd1,1});
        tbl.push_back('{0,0,8'd0,1,0,8'd3,0});
        tbl.push_back('{0,1,8'd77,1,0,8'd77,0});
        tbl.push_back('{0,0,8'd0,1,0,8'd79,0});
        tbl.push_back('{1,1,8'd77,1,0,8'd1,0});
        tbl.push_back('{0,0,8'd0,0,0,8'd1,0});
        tbl.push_back('{0,1,8'd254,0,0,8'd254,0});
        tbl.push_back('{0,0,8'd0,1,0,8'd254,1});
        tbl.push_back('{0,1,8'd0,0,0,8'd0,0});
        tbl.push_back('{0,0,8'd0,1,1,8'd0,1});
        tbl.push_back('{0,1,8'd3,0,0,8'd3,0});
        tbl.push_back('{0,0,8'd0,1,1,8'd1,0});
        tbl.push_back('{0,1,8'd255,0,0,8'd255,0});
        tbl.push_back('{0,0,8'd0,1,0,8'd255,1});
        tbl.push_back('{0,0,8'd0,1,0,8'd255,1});
`else
        tbl.push_back('{0,0,8'd0,1,1,8'd255,1});
        tbl.push_back('{0,0,8'd0,1,1,8'd253,0});
        tbl.push_back('{0,0,8'd0,1,1,8'd251,0});
        tbl.push_back('{0,1,8'd77,1,0,8'd77,0});
        tbl.push_back('{0,0,8'd0,1,0,8'd79,0});
        tbl.push_back('{1,1,8'd77,1,0,8'd1,0});
        tbl.push_back('{0,0,8'd0,0,0,8'd1,0});
        tbl.push_back('{0,1,8'd254,0,0,8'd254,0});
        tbl.push_back('{0,0,8'd0,1,0,8'd1,1});
        tbl.push_back('{0,1,8'd0,0,0,8'd0,0});
        tbl.push_back('{0,0,8'd0,1,1,8'd255,1});
        tbl.push_back('{0,1,8'd3,0,0,8'd3,0});
        tbl.push_back('{0,0,8'd0,1,1,8'd1,0});
        tbl.push_back('{0,0,8'd0,1,0,8'd3,0});
        tbl.push_back('{0,0,8'd0,1,1,8'd1,0});
        tbl.push_back('{0,0,8'd0,1,1,8'd255,1});
`endif
        repeat (2) @(negedge clk);
        chk("reset A cnt", longint'(cnt_a), 1);
        chk("reset A wrap", longint'(wrap_a), 0);
        chk("reset B cnt", longint'(cnt_b), 0);
        chk("reset B wrap", longint'(wrap_b), 0);
        reset_n = 1'b1;

        foreach (tbl[i]) begin
            drv(tbl[i].clr, tbl[i].ld, tbl[i].lv, tbl[i].en, tbl[i].dir);
            tick();
            chk($sformatf("vec%0d cnt", i), longint'(cnt_a), longint'(tbl[i].cnt));
            chk($sformatf("vec%0d wrap", i), longint'(wrap_a), longint'(tbl[i].wr));
        end

        drv(1, 0, 0, 0, 0);
        tick();
        drv(0, 0, 0, 1, 0);
        for (int i = 1; i <= 128; i++) begin
            tick();
            chk("run A cnt", longint'(cnt_a), SAT ? ((i >= 127) ? 255 : 1 + 2 * i) : ((i == 128) ? 1 : 1 + 2 * i));
            chk("run A wrap", longint'(wrap_a), longint'(i == 128));
        end

        drv(1, 0, 0, 0, 0);
        tick();
        drv(0, 0, 0, 1, 0);
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk("sweep B cnt", longint'(cnt_b), (i == 5) ? (SAT ? 12 : 0) : 3 * i);
            chk("sweep B wrap", longint'(wrap_b), longint'(i == 5));
        end
        drv(1, 0, 0, 0, 0);
        tick();
        drv(0, 0, 0, 1, 1);
        tick();
        chk("down B cnt", longint'(cnt_b), SAT ? 0 : 12);
        chk("down B wrap", longint'(wrap_b), 1);

        drv(1, 0, 0, 0, 0);
        tick();
        drv(0, 0, 0, 1, 0);
        repeat (50) tick();
        chk("pre-reset A cnt", longint'(cnt_a), 101);
        #2 reset_n = 1'b0;
        #1;
        chk("async A cnt", longint'(cnt_a), 1);
        chk("async A wrap", longint'(wrap_a), 0);
        chk("async B cnt", longint'(cnt_b), 0);
        ma = 1; wa = 0; mb = 0; wb = 0;
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        chk("resume A cnt 1", longint'(cnt_a), 3);
        tick();
        chk("resume A cnt 2", longint'(cnt_a), 5);

        repeat (400) begin
            drv($urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0, 8'($urandom),
                $urandom_range(0, 3) != 0, 1'($urandom));
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
